div32_iter: RTL and testbench

- Iterative 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU instructions, one quotient bit per cycle (restoring algorithm).
- Sits in the execute stage beside the combinational ALU and stalls the pipeline through valid/ready handshakes.
- Each step performs a trial subtraction of the divisor from the shifted partial remainder.
- Operand negation and result negation use the existing 32-bit subtractor.

---
 rtl/div32_iter_pkg.sv | 28 ++
 rtl/div32_iter_sub.sv | 15 +
 rtl/div32_iter.sv | 163 ++++++++++++++++
 tb/tb_div32_iter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/div32_iter_pkg.sv
// Shared definitions for the iterative RV32M divider.
package div32_iter_pkg;

    // funct3[1:0] encodings of the divide/remainder instructions
    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } div_state_e;

    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN       = 32'h8000_0000;
    localparam int unsigned ITER_COUNT    = 32;

    // op[0]=0 selects the signed flavours (DIV, REM)
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/div32_iter_sub.sv
// Plain two's-complement subtractor: diff_o = x_i - y_i (mod 2^W).
module div32_iter_sub #(
    parameter int W = 32
) (
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    output logic [W-1:0] diff_o
);

    // Combinational difference, wraps modulo 2^W
    always_comb begin
        diff_o = x_i - y_i;
    end

endmodule

// File: rtl/div32_iter.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Works on magnitudes; signs are reapplied in a single FIX cycle.
module div32_iter
    import div32_iter_pkg::*;
#(
    parameter int XLEN = 32          // only 32 is supported
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    div_state_e      state_q, state_d;
    logic            rem_sel_q, rem_sel_d;   // 1: return remainder
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] res_q, res_d;
    logic [5:0]      cnt_q, cnt_d;

    logic            accept;
    logic            sgn, a_neg, b_neg;
    logic            div0, ovf;
    logic [XLEN-1:0] neg_a_y, neg_a, neg_b;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   trial;

    // Kill blocks acceptance in the same cycle
    assign accept = in_valid & in_ready & ~kill;

    assign sgn   = op_is_signed(op);
    assign a_neg = sgn & dividend[XLEN-1];
    assign b_neg = sgn & divisor[XLEN-1];
    assign div0  = (divisor == '0);
    assign ovf   = sgn & (dividend == INT_MIN) & (divisor == DIV_BY_ZERO_Q);

    // The dividend negator doubles as the result negator in FIX
    assign neg_a_y = (state_q == S_FIX) ? (rem_sel_q ? rem_q : quo_q) : dividend;

    div32_iter_sub #(.W(XLEN)) u_neg_a (
        .x_i    ('0),
        .y_i    (neg_a_y),
        .diff_o (neg_a)
    );

    div32_iter_sub #(.W(XLEN)) u_neg_b (
        .x_i    ('0),
        .y_i    (divisor),
        .diff_o (neg_b)
    );

    assign a_mag = a_neg ? neg_a : dividend;
    assign b_mag = b_neg ? neg_b : divisor;

    // Trial subtraction of the divisor from the shifted partial remainder
    assign trial = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode; kill overrides everything
    always_comb begin
        state_d = state_q;
        if (kill) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (in_valid) state_d = (div0 | ovf) ? S_DONE : S_RUN;
                S_RUN:  if (cnt_q == 6'(ITER_COUNT - 1)) state_d = S_FIX;
                S_FIX:  state_d = S_DONE;
                S_DONE: if (out_ready) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Handshake outputs decoded from state
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
    end

    // Datapath next-state: capture, iterate, sign fix
    always_comb begin
        rem_sel_d = rem_sel_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        res_d     = res_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    rem_sel_d = op[1];
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    rem_d     = '0;
                    quo_d     = a_mag;
                    dvs_d     = b_mag;
                    cnt_d     = '0;
                    if (div0)     res_d = op[1] ? dividend : DIV_BY_ZERO_Q;
                    else if (ovf) res_d = op[1] ? '0 : INT_MIN;
                end
            end
            S_RUN: begin
                if (!trial[XLEN]) begin
                    rem_d = trial[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
                    quo_d = {quo_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q + 6'd1;
            end
            S_FIX: begin
                if (rem_sel_q) res_d = neg_rem_q ? neg_a : rem_q;
                else           res_d = neg_quo_q ? neg_a : quo_q;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_sel_q <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            res_q     <= '0;
            cnt_q     <= '0;
        end else begin
            rem_sel_q <= rem_sel_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            res_q     <= res_d;
            cnt_q     <= cnt_d;
        end
    end

    assign result = res_q;

endmodule

// File: tb/tb_div32_iter.sv
// Self-checking bench for div32_iter: directed cases plus randomized ops
// compared against an arithmetic reference model.
module tb_div32_iter;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        kill;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    int n_tests = 0;
    int n_fail  = 0;

    div32_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .dividend  (dividend),
        .divisor   (divisor),
        .kill      (kill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: RV32M semantics via 64-bit signed arithmetic
    function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'h0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0]) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
        end else begin
            sa = {32'h0, a};
            sb = {32'h0, b};
        end
        q = sa / sb;
        r = sa % sb;
        return o[1] ? r[31:0] : q[31:0];
    endfunction

    function automatic int ref_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'h0) return 1;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Issue one request; lat = cycles after the accept cycle until out_valid (-1 on timeout)
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        @(negedge clk);
        in_valid = 1'b1; op = o; dividend = a; divisor = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
        res = result;
    endtask

    // Consume the result and confirm the divider returns to idle
    task automatic pop(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_ovdrop"}, {31'b0, out_valid}, 32'd0);
        chk({tag, "_rdy"},    {31'b0, in_ready},  32'd1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            4:       return 32'h0 - 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Directed table: op, dividend, divisor, expected result, expected latency
    logic [1:0]  d_op  [10] = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b00, 2'b01, 2'b11, 2'b00, 2'b10, 2'b01};
    logic [31:0] d_a   [10] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7,
                                32'h1234_5678, 32'h1234_5678, 32'h8000_0000, 32'h8000_0000,
                                32'hFFFF_FFFF};
    logic [31:0] d_b   [10] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFE, 32'd0, 32'd0,
                                32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h10};
    logic [31:0] d_exp [10] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                                32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0000, 32'd0, 32'h0FFF_FFFF};
    int          d_lat [10] = '{34, 34, 34, 34, 34, 1, 1, 1, 1, 34};

    initial begin
        logic [31:0] res;
        int          lat;
        logic        seen;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        rst_n = 1'b0; in_valid = 1'b0; op = 2'b00; dividend = '0; divisor = '0;
        kill = 1'b0; out_ready = 1'b0;
        #1;
        chk("rst_rdy",    {31'b0, in_ready},  32'd1);
        chk("rst_ovalid", {31'b0, out_valid}, 32'd0);
        chk("rst_result", result,             32'd0);
        #20;
        @(negedge clk); rst_n = 1'b1;

        // Directed cases
        for (int i = 0; i < 10; i++) begin
            run_op(d_op[i], d_a[i], d_b[i], res, lat);
            chk($sformatf("dir%0d_res", i), res, d_exp[i]);
            chk($sformatf("dir%0d_lat", i), 32'(lat), 32'(d_lat[i]));
            pop($sformatf("dir%0d", i));
        end

        // Back-pressure: result must hold while out_ready is low
        run_op(2'b01, 32'd100, 32'd7, res, lat);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("hold_res",    result,             32'd14);
            chk("hold_ovalid", {31'b0, out_valid}, 32'd1);
            chk("hold_rdy",    {31'b0, in_ready},  32'd0);
        end
        pop("hold");

        // Kill during RUN cycle 10: no result ever appears
        @(negedge clk);
        in_valid = 1'b1; op = 2'b00; dividend = 32'd1000; divisor = 32'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        chk("kill_rdy",    {31'b0, in_ready},  32'd1);
        chk("kill_ovalid", {31'b0, out_valid}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("kill_noresult", {31'b0, seen}, 32'd0);

        // Request coincident with kill is dropped
        @(negedge clk);
        in_valid = 1'b1; kill = 1'b1; op = 2'b01; dividend = 32'd9; divisor = 32'd0;
        @(posedge clk); #1;
        in_valid = 1'b0; kill = 1'b0;
        chk("killreq_rdy",    {31'b0, in_ready},  32'd1);
        chk("killreq_ovalid", {31'b0, out_valid}, 32'd0);

        // Kill in DONE wins over out_ready
        run_op(2'b01, 32'd50, 32'd0, res, lat);
        @(negedge clk); kill = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0; out_ready = 1'b0;
        chk("killdone_ovalid", {31'b0, out_valid}, 32'd0);
        chk("killdone_rdy",    {31'b0, in_ready},  32'd1);

        // Asynchronous reset mid-RUN
        @(negedge clk);
        in_valid = 1'b1; op = 2'b01; dividend = 32'd12345; divisor = 32'd17;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ovalid", {31'b0, out_valid}, 32'd0);
        chk("arst_rdy",    {31'b0, in_ready},  32'd1);
        chk("arst_result", result,             32'd0);
        @(negedge clk); rst_n = 1'b1;
        run_op(2'b01, 32'hFFFF_FFFF, 32'h10, res, lat);
        chk("post_rst_res", res,      32'h0FFF_FFFF);
        chk("post_rst_lat", 32'(lat), 32'd34);
        pop("post_rst");

        // Randomized ops against the reference model
        for (int i = 0; i < 60; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = pick();
            rb = pick();
            run_op(ro, ra, rb, res, lat);
            chk($sformatf("rnd%0d_res op%0d %h/%h", i, ro, ra, rb), res, ref_res(ro, ra, rb));
            chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(ref_lat(ro, ra, rb)));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            chk($sformatf("rnd%0d_stable", i), result, ref_res(ro, ra, rb));
            pop($sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
